// File: rtl/rle_vli_decoder.sv
// Run-length / VLI expander: turns decoded Huffman symbols into 64 signed
// coefficients per 8x8 block in zigzag order, with DC prediction and ZRL/EOB handling.
module rle_vli_decoder #(
  parameter int DATA_WIDTH = 10,
  localparam int SIZE_W = $clog2(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_isDC,
  input  logic [3:0]              in_run,
  input  logic [SIZE_W-1:0]       in_size,
  input  logic [DATA_WIDTH-2:0]   in_vli,
  input  logic                    in_eop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_sop,
  output logic                    out_done,
  output logic                    out_eop,
  output logic                    err
);

  typedef enum logic [2:0] {EXP_DC, EXP_AC, RUN, VALUE, FILL} state_t;

  state_t                        state, state_n;
  logic                          rdy_en;
  logic [5:0]                    idx;
  logic [3:0]                    run_cnt, run_n;
  logic                          pend_vld, pend_n;
  logic signed [DATA_WIDTH-1:0]  pend_val, pval_n;
  logic signed [DATA_WIDTH-1:0]  dc_pred;
  logic                          eop_lat, eop_now;
  logic                          adv, accept, emit, dc_load, err_n, blk_end;
  logic signed [DATA_WIDTH-1:0]  emit_data, sym_val;

  // Inverse VLI: a clear top bit marks a negative value offset by 2^size-1.
  function automatic logic signed [DATA_WIDTH-1:0] vli_decode(
    input logic [SIZE_W-1:0]     sz,
    input logic [DATA_WIDTH-2:0] bits
  );
    logic [DATA_WIDTH-1:0] mask, mag, top;
    mask = (DATA_WIDTH'(1) << sz) - DATA_WIDTH'(1);
    mag  = {1'b0, bits} & mask;
    top  = mask ^ (mask >> 1);
    if (sz == '0)
      return '0;
    else if ((mag & top) != '0)
      return signed'(mag);
    else
      return signed'(mag - mask);
  endfunction

  assign adv      = !out_valid || out_ready;
  assign in_ready = rdy_en && adv &&
                    ((state == EXP_DC) || ((state == EXP_AC) && !in_isDC));
  assign accept   = in_valid && in_ready;
  assign sym_val  = vli_decode(in_size, in_vli);
  assign eop_now  = eop_lat || (accept && in_eop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EXP_DC;
    else        state <= state_n;
  end

  // Every accepted AC symbol emits its first beat in the same cycle so the
  // stream keeps one coefficient per clock.
  always_comb begin
    state_n   = state;
    run_n     = run_cnt;
    pend_n    = pend_vld;
    pval_n    = pend_val;
    emit      = 1'b0;
    emit_data = '0;
    dc_load   = 1'b0;
    err_n     = 1'b0;
    blk_end   = 1'b0;
    if (adv) begin
      unique case (state)
        EXP_DC: if (accept) begin
          if (in_isDC) begin
            emit      = 1'b1;
            emit_data = dc_pred + sym_val;
            dc_load   = 1'b1;
            state_n   = EXP_AC;
          end else begin
            err_n = 1'b1;
          end
        end
        EXP_AC: if (in_valid && in_isDC) begin
          err_n   = 1'b1;
          emit    = 1'b1;
          state_n = FILL;
        end else if (accept) begin
          emit = 1'b1;
          if (in_size == '0 && in_run == 4'd0) begin
            state_n = FILL;
          end else if (in_size == '0 && in_run == 4'd15) begin
            run_n   = 4'd15;
            pend_n  = 1'b0;
            state_n = RUN;
          end else if (in_run == 4'd0) begin
            emit_data = sym_val;
          end else begin
            run_n   = in_run - 4'd1;
            pend_n  = 1'b1;
            pval_n  = sym_val;
            state_n = (in_run == 4'd1) ? VALUE : RUN;
          end
        end
        RUN: begin
          emit  = 1'b1;
          run_n = run_cnt - 4'd1;
          if (run_n == 4'd0) state_n = pend_vld ? VALUE : EXP_AC;
        end
        VALUE: begin
          emit      = 1'b1;
          emit_data = pend_val;
          pend_n    = 1'b0;
          state_n   = EXP_AC;
        end
        FILL:    emit = 1'b1;
        default: state_n = EXP_DC;
      endcase
      // Index 63 always closes the block; anything still queued is an overrun.
      if (emit && idx == 6'd63) begin
        blk_end = 1'b1;
        if (state_n == RUN || state_n == VALUE) err_n = 1'b1;
        state_n = EXP_DC;
        pend_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      idx       <= '0;
      run_cnt   <= '0;
      pend_vld  <= 1'b0;
      dc_pred   <= '0;
      eop_lat   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_done  <= 1'b0;
      out_eop   <= 1'b0;
      err       <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      err      <= err_n;
      run_cnt  <= run_n;
      pend_vld <= pend_n;
      if (adv) begin
        out_valid <= emit;
        out_data  <= emit_data;
        out_sop   <= emit && (idx == 6'd0);
        out_done  <= blk_end;
        out_eop   <= blk_end && eop_now;
      end
      if (emit) idx <= blk_end ? 6'd0 : idx + 6'd1;
      if (blk_end)                eop_lat <= 1'b0;
      else if (accept && in_eop)  eop_lat <= 1'b1;
      if (blk_end && eop_now)     dc_pred <= '0;
      else if (dc_load)           dc_pred <= emit_data;
    end
  end

  always_ff @(posedge clk) begin
    pend_val <= pval_n;
  end

endmodule
